task3_q2: RTL and testbench
===========================

# task3_q2

Registered 4-input Boolean function evaluator. Maps a 4-bit input vector {A,B,C,D} to a single output bit Y through a 16-entry truth table; the output is registered on the system clock. It is used as a small combinational-decode leaf block whose result feeds synchronous logic downstream. The truth table is fixed by default and can optionally be made run-time programmable.

## Interface
Parameters:
- TT_INIT, 16'h0727, truth-table value after reset; bit i is Y for input value i (minterms 0,1,2,5,8,9,10).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  reset, active-low, asynchronous assert, synchronous release by design of the driver
- a  input  4  operand; a[3]=A, a[2]=B, a[1]=C, a[0]=D (A is MSB)
- y  output  1  registered function value
- y_valid  output  1  high once y holds a value computed from sampled a
- cfg_we  input  1  truth-table write strobe (present only with TASK3_Q2_PROG_EN)
- cfg_tt  input  16  new truth-table value (present only with TASK3_Q2_PROG_EN)

One clock (clk); reset rst_n is asynchronous and active-low.

## Operation
- Function: y_next = tt[a], where tt is the 16-bit truth table and a is treated as an unsigned index 0..15.
- Default function (tt = 16'h0727): Y = 1 for a in {0,1,2,5,8,9,10}, else 0. Equivalent SOP: B'D' + B'C' + A'C'D.
- No X-propagation handling: a must be a known value; y for unknown a is don't-care.
- y_valid rises on the first clk edge after rst_n deasserts and stays high until next reset.
- Programmable variant: on a clk edge with cfg_we=1, tt <= cfg_tt.

## Timing
- Reset (rst_n=0, asynchronous): y=0, y_valid=0, tt=TT_INIT immediately, independent of clk.
- Latency: one cycle. y after edge k equals tt[a] with a sampled at edge k.
- Throughput: one new a per cycle; every cycle's a produces a result.
- Simultaneous cfg_we and lookup at the same edge: lookup uses the old tt; new tt affects y from the next edge on.
- Reset asserted mid-stream: outputs clear at once; the first y after release reflects a at the first post-release edge, using TT_INIT (any programmed table is lost).
- cfg_we while rst_n=0: ignored.

## Configuration
- Macro TASK3_Q2_PROG_EN.
- Defined: cfg_we/cfg_tt ports exist; tt is a 16-bit register reset to TT_INIT and writable as above.
- Undefined: ports absent; tt is the constant TT_INIT (pure lookup, no table register).

## Structure
- Shared package task3_q2_pkg: TT_W=16, IDX_W=4, default constant TT_DEFAULT=16'h0727, minterm list as documentation constants.
- One sub-module: tt_lookup (combinational 16:1 mux, index a, table tt, output bit); top holds tt register, y/y_valid flops.

## Test plan
- Reset: hold rst_n=0 with a=4'h0 toggling clk -> y=0, y_valid=0; release -> after one edge y=1, y_valid=1.
- Exhaustive sweep a=0..15, one per cycle, default table -> y sequence 1,1,1,0,0,1,0,0,1,1,1,0,0,0,0,0 delayed one cycle.
- Async reset mid-sweep: assert rst_n=0 between edges while a=4'h5 -> y drops to 0 without a clock edge.
- Programming (PROG_EN): cfg_tt=16'h8000 with cfg_we=1 and a=4'hF at the same edge -> y=0 (old table); next edge a=4'hF -> y=1; a=4'h0 -> y=0.
- Reset after programming: pulse rst_n, then a=4'h2 -> y=1 (TT_INIT restored).
- Build without TASK3_Q2_PROG_EN: same sweep as scenario 2 passes; cfg ports absent.

Source files
------------

// File: rtl/task3_q2_pkg.sv
// Shared constants for the registered 4-input truth-table evaluator.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: table/index widths, the default minterm list and the table derived from it.
package task3_q2_pkg;

   localparam int TT_W  = 16;
   localparam int IDX_W = 4;

   // Default function minterms {0,1,2,5,8,9,10}, packed as 4-bit entries (entry 0 in LSBs).
   localparam int          N_MINTERMS   = 7;
   localparam logic [27:0] MINTERM_LIST = {4'd10, 4'd9, 4'd8, 4'd5, 4'd2, 4'd1, 4'd0};

   // Build a truth table with a 1 at every listed minterm.
   function automatic logic [TT_W-1:0] tt_from_minterms(input logic [27:0] list);
      logic [TT_W-1:0] tt;
      tt = '0;
      for (int k = 0; k < N_MINTERMS; k++) begin
         tt[list[k*IDX_W +: IDX_W]] = 1'b1;
      end
      return tt;
   endfunction

   // Equals 16'h0727: Y = B'D' + B'C' + A'C'D.
   localparam logic [TT_W-1:0] TT_DEFAULT = tt_from_minterms(MINTERM_LIST);

endpackage : task3_q2_pkg

// File: rtl/task3_q2_tt_lookup.sv
// Combinational 16:1 truth-table mux: bit = tt[idx].
// Latency: zero (pure combinational).
// Backpressure: none; evaluates every cycle.
// Ports: idx (table index), tt (truth table), bit_o (selected table bit).
module task3_q2_tt_lookup
   import task3_q2_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic [TT_W-1:0]  tt,
   output logic             bit_o
);

   assign bit_o = tt[idx];

endmodule : task3_q2_tt_lookup

// File: rtl/task3_q2.sv
// Registered 4-input Boolean function: y = tt[a] captured on clk.
// Latency: one cycle; y_valid high from the first edge after reset release.
// Backpressure: none; a new a is accepted and produces a result every cycle.
// Ports: clk, rst_n (async active-low), a[3:0] = {A,B,C,D}, y, y_valid;
//        cfg_we/cfg_tt table write port exists only when TASK3_Q2_PROG_EN is defined.
// Build option: TASK3_Q2_PROG_EN makes the table a run-time writable register.
module task3_q2
   import task3_q2_pkg::*;
#(
   parameter logic [TT_W-1:0] TT_INIT = TT_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] a,
`ifdef TASK3_Q2_PROG_EN
   input  logic             cfg_we,
   input  logic [TT_W-1:0]  cfg_tt,
`endif
   output logic             y,
   output logic             y_valid
);

   logic [TT_W-1:0] tt;
   logic            y_nxt;

`ifdef TASK3_Q2_PROG_EN
   // Lookup reads the current register value, so a write and a lookup on the
   // same edge use the old table; the new table is seen from the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt <= TT_INIT;
      end else if (cfg_we) begin
         tt <= cfg_tt;
      end
   end
`else
   assign tt = TT_INIT;
`endif

   task3_q2_tt_lookup u_tt_lookup (
      .idx   (a),
      .tt    (tt),
      .bit_o (y_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y       <= 1'b0;
         y_valid <= 1'b0;
      end else begin
         y       <= y_nxt;
         y_valid <= 1'b1;
      end
   end

endmodule : task3_q2

// File: tb/tb_task3_q2.sv
// Directed self-checking bench for task3_q2 (default and TASK3_Q2_PROG_EN builds).
// Latency under test: one cycle from a to y.
// Backpressure: none exercised (block has none).
module tb_task3_q2;

   logic        clk;
   logic        rst_n;
   logic [3:0]  a;
   logic        y;
   logic        y_valid;
`ifdef TASK3_Q2_PROG_EN
   logic        cfg_we;
   logic [15:0] cfg_tt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Hand-written default table: minterms 0,1,2,5,8,9,10.
   logic [15:0] exp_tt;

   task3_q2 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
`ifdef TASK3_Q2_PROG_EN
      .cfg_we  (cfg_we),
      .cfg_tt  (cfg_tt),
`endif
      .y       (y),
      .y_valid (y_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_tt = 16'h0727;
      rst_n  = 1'b0;
      a      = 4'h0;
`ifdef TASK3_Q2_PROG_EN
      cfg_we = 1'b0;
      cfg_tt = 16'h0000;
`endif

      // Reset held across several edges.
      repeat (3) tick();
      check("rst_y", y, 1'b0);
      check("rst_vld", y_valid, 1'b0);

      // Release between edges; first edge samples a=0 -> y=1.
      rst_n = 1'b1;
      tick();
      check("rel_y", y, 1'b1);
      check("rel_vld", y_valid, 1'b1);

      // Exhaustive sweep, one index per cycle.
      for (int i = 0; i < 16; i++) begin
         a = i[3:0];
         tick();
         check($sformatf("sweep_y[%0d]", i), y, exp_tt[i]);
         check($sformatf("sweep_vld[%0d]", i), y_valid, 1'b1);
      end

      // Asynchronous reset mid-stream while a=5.
      a = 4'h5;
      tick();
      check("pre_async_y", y, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_y", y, 1'b0);
      check("async_vld", y_valid, 1'b0);
      #1;
      rst_n = 1'b1;
      a     = 4'h2;
      tick();
      check("post_async_y", y, 1'b1);
      check("post_async_vld", y_valid, 1'b1);
      a = 4'h3;
      tick();
      check("post_async_y3", y, 1'b0);

`ifdef TASK3_Q2_PROG_EN
      // Write and lookup on the same edge: old table applies.
      a      = 4'hF;
      cfg_tt = 16'h8000;
      cfg_we = 1'b1;
      tick();
      check("prog_same_edge", y, 1'b0);
      cfg_we = 1'b0;
      tick();
      check("prog_new_f", y, 1'b1);
      a = 4'h0;
      tick();
      check("prog_new_0", y, 1'b0);
      a = 4'h2;
      tick();
      check("prog_new_2", y, 1'b0);

      // Reset restores TT_INIT; a write during reset is ignored.
      rst_n  = 1'b0;
      cfg_we = 1'b1;
      cfg_tt = 16'h0000;
      tick();
      rst_n  = 1'b1;
      cfg_we = 1'b0;
      a      = 4'h2;
      tick();
      check("prog_rst_2", y, 1'b1);
      a = 4'hF;
      tick();
      check("prog_rst_f", y, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_task3_q2
